// File: rtl/tdc_cmd_rx_pkg.sv
// Shared definitions for the MCU->FPGA command path: opcodes, FSM state types
// and the bit-period computation used by the receiver and the parser timeout.
package tdc_cmd_rx_pkg;

    localparam logic [7:0] OP_SEL  = 8'h53;  // 'S'
    localparam logic [7:0] OP_AUTO = 8'h41;  // 'A'
    localparam logic [7:0] OP_CAP  = 8'h43;  // 'C'

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    typedef enum logic {
        P_WAIT_OP,
        P_WAIT_ARG
    } parse_state_e;

    // Clocks per bit, rounded to nearest.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_SEL) || (b == OP_AUTO) || (b == OP_CAP);
    endfunction

endpackage

// File: rtl/tdc_cmd_rx_uart.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, registered
// byte/valid/framing-error outputs.
module uart_rx_8n1
    import tdc_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk10m,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int HALF_CLKS = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             sync1_q, rs_q, rs_prev_q;

    wire fall = rs_prev_q & ~rs_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk10m) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rxd;
            rs_q      <= sync1_q;
            rs_prev_q <= rs_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // NOTE: every variable gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d   = RX_START;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rs_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rs_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = RX_STOP;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rs_q) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_BREAK: begin
                // Hold off until the line returns high so a long low level
                // cannot be mistaken for a new start bit.
                if (rs_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte   = byte_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/tdc_cmd_rx.sv
// Inbound command path: UART receiver plus 2-byte opcode/argument parser that
// programs the TDC tap-select and capture-enable controls.
module tdc_cmd_rx
    import tdc_cmd_rx_pkg::*;
#(
    parameter int CLK_HZ       = 10_000_000,
    parameter int BAUD         = 115200,
    parameter int SEL_W        = 5,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic             clk10m,
    input  logic             rst,
    input  logic             rxd,
    output logic [7:0]       rx_byte,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             cmd_err,
    output logic [SEL_W-1:0] sel_out,
    output logic             sel_auto,
    output logic             cap_en
);

    localparam int CPB     = clks_per_bit(CLK_HZ, BAUD);
    localparam int TO_CLKS = TIMEOUT_BITS * CPB;
    localparam int TO_W    = $clog2(TO_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CLKS - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk10m    (clk10m),
        .rst       (rst),
        .rxd       (rxd),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    parse_state_e     pstate_q, pstate_d;
    logic [7:0]       op_q, op_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             auto_q, auto_d;
    logic             cap_q, cap_d;
    logic             cerr_q, cerr_d;

    always_ff @(posedge clk10m) begin
        if (rst) begin
            pstate_q <= P_WAIT_OP;
            op_q     <= '0;
            to_cnt_q <= '0;
            sel_q    <= '0;
            auto_q   <= 1'b1;
            cap_q    <= 1'b1;
            cerr_q   <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            op_q     <= op_d;
            to_cnt_q <= to_cnt_d;
            sel_q    <= sel_d;
            auto_q   <= auto_d;
            cap_q    <= cap_d;
            cerr_q   <= cerr_d;
        end
    end

    always_comb begin
        pstate_d = pstate_q;
        op_d     = op_q;
        to_cnt_d = to_cnt_q;
        sel_d    = sel_q;
        auto_d   = auto_q;
        cap_d    = cap_q;
        cerr_d   = 1'b0;
        unique case (pstate_q)
            P_WAIT_OP: begin
                if (rx_valid) begin
                    if (is_opcode(rx_byte)) begin
                        op_d     = rx_byte;
                        to_cnt_d = '0;
                        pstate_d = P_WAIT_ARG;
                    end else begin
                        cerr_d = 1'b1;
                    end
                end
            end
            P_WAIT_ARG: begin
                // An argument arriving on the expiry cycle still applies.
                if (rx_valid) begin
                    pstate_d = P_WAIT_OP;
                    case (op_q)
                        OP_SEL: begin
                            sel_d  = rx_byte[SEL_W-1:0];
                            auto_d = 1'b0;
                        end
                        OP_AUTO: auto_d = rx_byte[0];
                        OP_CAP:  cap_d  = rx_byte[0];
                        default: ;
                    endcase
                end else if (to_cnt_q == TO_LAST) begin
                    cerr_d   = 1'b1;
                    pstate_d = P_WAIT_OP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            default: pstate_d = P_WAIT_OP;
        endcase
    end

    assign cmd_err  = cerr_q;
    assign sel_out  = sel_q;
    assign sel_auto = auto_q;
    assign cap_en   = cap_q;

endmodule
